// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// DMEM_ERR_EN enables access error detection; undefined means accesses are coerced.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      DM_B  = 3'b000,
      DM_H  = 3'b001,
      DM_W  = 3'b010,
      DM_BU = 3'b100,
      DM_HU = 3'b101
   } dmem_ctrl_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic              misalign;
   } store_res_t;

   // Size/alignment/code legality; index range is checked by the responder itself.
   function automatic logic access_err(input logic [2:0] ctrl, input logic [1:0] lane,
                                       input logic wr);
`ifdef DMEM_ERR_EN
      logic err;
      case (ctrl)
         DM_B:    err = 1'b0;
         DM_BU:   err = wr;
         DM_H:    err = lane[0];
         DM_HU:   err = wr | lane[0];
         DM_W:    err = (lane != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
`else
      return 1'b0;
`endif
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the load/store unit and the responder.
interface dmem_responder_if;

   logic                        req_valid;
   logic                        req_ready;
   logic                        req_wr;
   logic [2:0]                  req_ctrl;
   logic [dmem_pkg::WORD_W-1:0] req_addr;
   logic [dmem_pkg::WORD_W-1:0] req_wdata;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [dmem_pkg::WORD_W-1:0] rsp_rdata;
   logic                        rsp_err;

   modport master (
      output req_valid, req_wr, req_ctrl, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, req_ctrl, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane steering: load extraction with extension, store lane merge.
// Misalign flag is only ever raised when DMEM_ERR_EN is defined.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [WORD_W-1:0] wdata,
   input  logic [1:0]        lane,
   input  logic [2:0]        ctrl,
   input  logic              wr,
   output logic [WORD_W-1:0] rdata,
   output logic [WORD_W-1:0] merged,
   output logic              misalign
);

   // Halves select on lane[1] only and words ignore the lane, which is the coerced alignment.
   function automatic logic [WORD_W-1:0] load(input logic [WORD_W-1:0] w,
                                              input logic [1:0] a, input logic [2:0] c);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {a, 3'b000});
      h = a[1] ? w[31:16] : w[15:0];
      case (c[1:0])
         2'b00:   return c[2] ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   return c[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   function automatic store_res_t store(input logic [WORD_W-1:0] old,
                                        input logic [WORD_W-1:0] d,
                                        input logic [1:0] a, input logic [2:0] c);
      store_res_t res;
      res.word = old;
      case (c[1:0])
         2'b00:   res.word[{a, 3'b000} +: 8] = d[7:0];
         2'b01:   res.word = a[1] ? {d[15:0], old[15:0]} : {old[31:16], d[15:0]};
         default: res.word = d;
      endcase
      res.misalign = access_err(c, a, 1'b1);
      return res;
   endfunction

   store_res_t st;

   always_comb begin
      st       = store(word, wdata, lane, ctrl);
      rdata    = load(word, lane, ctrl);
      merged   = st.word;
      misalign = wr ? st.misalign : access_err(ctrl, lane, 1'b0);
   end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed LATENCY, held response.
// DMEM_ERR_EN enables rsp_err generation; otherwise accesses are aligned and indices wrap.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_e state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              cap_wr;
   logic [2:0]        cap_ctrl;
   logic [WORD_W-1:0] cap_addr;
   logic [WORD_W-1:0] cap_wdata;
   logic [WORD_W-1:0] rdata_q;
   logic              err_q;

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   logic              accept;
   logic              execute;
   logic              op_wr;
   logic [2:0]        op_ctrl;
   logic [WORD_W-1:0] op_addr;
   logic [WORD_W-1:0] op_wdata;
   logic [IDX_W-1:0]  idx;
   logic              range_err;
   logic              op_err;
   logic [WORD_W-1:0] old_word;
   logic [WORD_W-1:0] ld_data;
   logic [WORD_W-1:0] st_word;
   logic              misalign;

   assign accept = bus.req_valid && bus.req_ready;

   // With LATENCY==1 the access executes on the accept edge, so operands come straight from the bus.
   always_comb begin
      execute  = 1'b0;
      if (LATENCY == 1) execute = accept;
      else if (state == WAIT && cnt == CNT_W'(1)) execute = 1'b1;
      op_wr    = (state == IDLE) ? bus.req_wr    : cap_wr;
      op_ctrl  = (state == IDLE) ? bus.req_ctrl  : cap_ctrl;
      op_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
      op_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
      idx      = IDX_W'(op_addr[31:2] % 30'(DEPTH_WORDS));
`ifdef DMEM_ERR_EN
      range_err = (32'(op_addr[31:2]) >= DEPTH_WORDS);
`else
      range_err = 1'b0;
`endif
      op_err   = misalign | range_err;
   end

   assign old_word = mem[idx];

   dmem_lane_align u_lane (
      .word     (old_word),
      .wdata    (op_wdata),
      .lane     (op_addr[1:0]),
      .ctrl     (op_ctrl),
      .wr       (op_wr),
      .rdata    (ld_data),
      .merged   (st_word),
      .misalign (misalign)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE) && reset;
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         cap_wr    <= 1'b0;
         cap_ctrl  <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cap_wr    <= bus.req_wr;
            cap_ctrl  <= bus.req_ctrl;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (execute) begin
            rdata_q <= (op_wr || op_err) ? '0 : ld_data;
            err_q   <= op_err;
         end else if (state == RESP && bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset; execute is never high while reset is asserted.
   always_ff @(posedge clk) begin
      if (execute && op_wr && !op_err) mem[idx] <= st_word;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, backpressure/reset sequences, random vs byte-array model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 2;
`ifdef DMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   bit [7:0] model_b [DEPTH*4];

   typedef struct {
      bit        wr;
      bit [2:0]  ctrl;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] exp_rdata;
      bit        exp_err;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: no handshake within bound", name);
   endtask

   // Reference: storage is a flat little-endian byte array; sizes and extension by arithmetic.
   task automatic model_access(input bit wr, input bit [2:0] ctrl, input bit [31:0] addr,
                               input bit [31:0] wdata, output bit [31:0] rd, output bit err);
      int unsigned size;
      int unsigned base;
      bit sgn;
      bit illegal;
      bit [31:0] val;
      illegal = 1'b0;
      sgn     = 1'b0;
      case (ctrl)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: size = 1;
         3'd5: size = 2;
         default: begin size = 4; illegal = 1'b1; end
      endcase
      err = 1'b0;
      rd  = 0;
      if (ERR_EN && (illegal || (wr && (ctrl == 3'd4 || ctrl == 3'd5)) ||
                     (addr % size) != 0 || (addr / 4) >= DEPTH))
         err = 1'b1;
      if (err) return;
      base = ((addr / 4) % DEPTH) * 4 + ((addr % 4) / size) * size;
      if (wr) begin
         for (int i = 0; i < size; i++) model_b[base + i] = 8'(wdata >> (8 * i));
         return;
      end
      val = 0;
      for (int i = 0; i < size; i++) val = val | (32'(model_b[base + i]) << (8 * i));
      if (sgn && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 1);
      rd = val;
   endtask

   // Issues one request, checks latency and response stability under 'hold' cycles of backpressure.
   task automatic do_req(input bit wr, input bit [2:0] ctrl, input bit [31:0] addr,
                         input bit [31:0] wdata, input int unsigned hold, input bit junk,
                         output bit [31:0] rd, output bit er);
      int unsigned n;
      rd = 0;
      er = 0;
      @(negedge clk);
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.req_ready) begin timeout("req_accept"); return; end
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_ctrl  = ctrl;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clk);
      #1;
      bus.req_valid = junk;
      bus.req_wr    = 1'($urandom);
      bus.req_ctrl  = 3'($urandom);
      bus.req_addr  = $urandom % (DEPTH * 4);
      bus.req_wdata = $urandom;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
      if (!bus.rsp_valid) begin bus.req_valid = 1'b0; timeout("rsp_valid"); return; end
      check("latency", n, LAT);
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      for (int i = 0; i < int'(hold); i++) begin
         @(negedge clk);
         check("hold_valid", bus.rsp_valid, 1'b1);
         check("hold_rdata", bus.rsp_rdata, rd);
         check("hold_err", bus.rsp_err, er);
         check("hold_req_ready", bus.req_ready, 1'b0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
   endtask

   function automatic void add_vec(input bit wr, input bit [2:0] ctrl, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [31:0] exp_rdata,
                                   input bit exp_err);
      vec_t v;
      v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      tbl.push_back(v);
   endfunction

   initial begin
      bit [31:0] rd, mrd;
      bit er, mer;
      bit wr;
      bit [2:0] ctrl;
      bit [31:0] addr;

      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_ctrl  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err", bus.rsp_err, 1'b0);
      rst_n = 1'b1;
      #1;
      check("post_rst_req_ready", bus.req_ready, 1'b1);

      for (int i = 0; i < int'(DEPTH); i++) begin
         addr = 32'(i * 4);
         mrd  = $urandom;
         do_req(1'b1, 3'd2, addr, mrd, 0, 1'b0, rd, er);
         model_access(1'b1, 3'd2, addr, mrd, rd, er);
      end

      add_vec(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      add_vec(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      add_vec(1, 3'd0, 32'h11, 32'hFFFFFF80, 32'h0, 0);
      add_vec(0, 3'd0, 32'h11, 32'h0, 32'hFFFFFF80, 0);
      add_vec(0, 3'd4, 32'h11, 32'h0, 32'h00000080, 0);
      add_vec(0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 0);
      add_vec(0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
      add_vec(0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 0);
      add_vec(1, 3'd2, 32'h14, 32'h11223344, 32'h0, 0);
      add_vec(0, 3'd1, 32'h13, 32'h0, ERR_EN ? 32'h0 : 32'hFFFFDEAD, ERR_EN);
      add_vec(1, 3'd2, 32'h16, 32'hCAFEF00D, 32'h0, ERR_EN);
      add_vec(0, 3'd2, 32'h14, 32'h0, ERR_EN ? 32'h11223344 : 32'hCAFEF00D, 0);
      add_vec(1, 3'd2, 32'h0, 32'hA5A55A5A, 32'h0, 0);
      add_vec(1, 3'd1, 32'h2, 32'h1234BEEF, 32'h0, 0);
      add_vec(0, 3'd2, 32'h0, 32'h0, 32'hBEEF5A5A, 0);
      add_vec(0, 3'd2, 32'(DEPTH * 4), 32'h0, ERR_EN ? 32'h0 : 32'hBEEF5A5A, ERR_EN);
      add_vec(0, 3'd7, 32'h10, 32'h0, ERR_EN ? 32'h0 : 32'hDEAD80EF, ERR_EN);
      if (ERR_EN) add_vec(1, 3'd4, 32'h10, 32'h00000077, 32'h0, 1);
      add_vec(0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 0);

      foreach (tbl[i]) begin
         do_req(tbl[i].wr, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata, 0, 1'b0, rd, er);
         model_access(tbl[i].wr, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata, mrd, mer);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
      end

      // Backpressure: response held 5 cycles, then req_ready returns only the cycle after consumption.
      do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1, rd, er);
      check("bp_rdata", rd, 32'hDEAD80EF);
      check("bp_err", er, 1'b0);
      @(negedge clk);
      check("bp_req_ready_after", bus.req_ready, 1'b1);
      check("bp_rsp_valid_after", bus.rsp_valid, 1'b0);

      for (int i = 0; i < 300; i++) begin
         wr = 1'($urandom);
         case ($urandom_range(0, 9))
            0, 1:    ctrl = 3'd0;
            2, 3:    ctrl = 3'd1;
            4, 5:    ctrl = 3'd2;
            6:       ctrl = 3'd4;
            7:       ctrl = 3'd5;
            default: ctrl = 3'($urandom_range(0, 7));
         endcase
         if (!ERR_EN && wr && (ctrl == 3'd4 || ctrl == 3'd5)) ctrl = ctrl & 3'b011;
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = $urandom_range(0, DEPTH * 4 + 63);
         mrd = $urandom;
         do_req(wr, ctrl, addr, mrd, $urandom_range(0, 2), 1'($urandom), rd, er);
         model_access(wr, ctrl, addr, mrd, mrd, mer);
         check($sformatf("rand%0d_rdata", i), rd, mrd);
         check($sformatf("rand%0d_err", i), er, mer);
      end

      // Reset during WAIT must discard the uncommitted store.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_ctrl  = 3'd2;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", bus.req_ready, 1'b0);
      check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("midrst_rsp_err", bus.rsp_err, 1'b0);
      repeat (2) @(negedge clk);
      check("midrst_hold_rsp_valid", bus.rsp_valid, 1'b0);
      rst_n = 1'b1;
      #1;
      check("midrst_release_req_ready", bus.req_ready, 1'b1);
      do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
      model_access(1'b0, 3'd2, 32'h20, 32'h0, mrd, mer);
      check("midrst_old_contents", rd, mrd);
      check("midrst_old_err", er, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the processor's load/store port (address, write enable, DMCtrl size/sign code, write data).
- Replaces the combinational data memory wherever a multi-cycle or stallable memory is needed.
- Accepts one request at a time, performs the byte/half/word access after a fixed latency, and holds a registered response until it is consumed.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  a request is presented.
- req_ready  output  1  responder can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_ctrl  input  3  DMCtrl code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response is available.
- rsp_ready  input  1  the initiator consumes the response.
- rsp_rdata  output  32  load result, extended per req_ctrl; 0 for stores and errors.
- rsp_err  output  1  the access was rejected.

Behaviour:
- Reset values: req_ready=0 while reset is asserted, 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0.
- Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A handshake (req_valid && req_ready) captures wr/ctrl/addr/wdata into registers. Next state is WAIT with counter=LATENCY-1, or RESP directly when LATENCY==1.
- WAIT: req_ready=0. Counter decrements each cycle. In the cycle the counter reaches 0, the access executes and the state moves to RESP.
- Store commit: a store writes storage at the WAIT→RESP edge (the IDLE→RESP edge when LATENCY==1).
- Load capture: a load samples storage at the same edge.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_ready=1. On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid. req_ready returns to 1 the next cycle (no same-cycle request acceptance in RESP).
- Backpressure: any number of cycles with rsp_ready=0 in RESP has no side effects.
- Byte order is little-endian. Word index = addr[31:2]. Lane select = addr[1:0] for bytes, addr[1] for halves.
- Loads: B/H sign-extend, BU/HU zero-extend, W returns the full word.
- Stores: B/H write only the addressed lane(s) using req_wdata[7:0] or [15:0]; other lanes are preserved. BU/HU codes on a store are errors.
- Errors (rsp_err=1, no write, rsp_rdata=0, one response still returned):
  - addr[31:2] >= DEPTH_WORDS;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - ctrl 011, 110, 111.
- Latency is exactly LATENCY cycles from the accept edge to the first rsp_valid=1 cycle, independent of request type.
- Reset mid-operation returns to IDLE immediately. A store not yet committed is discarded; a committed store persists. Any pending response is dropped.
- Inputs are ignored whenever req_ready=0.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: full error checking as above.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned accesses are force-aligned: addr[0] is ignored for halves, addr[1:0] for words.
  - Out-of-range indices wrap modulo DEPTH_WORDS.
  - Illegal ctrl codes behave as W.

Decomposition:
- Package dmem_pkg:
  - enum dmem_ctrl_e (DM_B=3'b000, DM_H=3'b001, DM_W=3'b010, DM_BU=3'b100, DM_HU=3'b101);
  - enum dmem_state_e (IDLE, WAIT, RESP);
  - localparam WORD_W=32.
- Sub-module dmem_lane_align (combinational), two functions:
  - load: word + addr[1:0] + ctrl → extended rdata;
  - store: old word + wdata + addr[1:0] + ctrl → merged word and misalign flag.
- The FSM, counter, and storage array stay in dmem_responder.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 → each rsp_valid arrives exactly 2 cycles after its accept; load rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x11 over 0xDEADBEEF, then LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080; LW @0x10 → 0xDEAD80EF.
- LH @0x12 → 0xFFFFDEAD; LHU @0x12 → 0x0000DEAD; LH @0x13 → err=1, rdata=0; SW @0x16 → err=1, word @0x14 unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rdata, err stable and req_ready=0 throughout; after rsp_ready=1, req_ready=1 on the following cycle.
- LW @ (DEPTH_WORDS*4) → err=1. With DMEM_ERR_EN undefined → returns the word @0x0, err=0.
- SW 0x12345678 @0x20 accepted, reset asserted in WAIT → outputs return to reset values; LW @0x20 after release returns the old contents, not 0x12345678.
